// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order instruction FIFO to ID, redirect flush. Optional perf counters: IFU_PERF_CNT_EN.
module ifu_fetch_stage #(
    parameter logic [63:0] RESET_PC        = 64'h8000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        validout,
    output logic [31:0] inst,
    output logic [63:0] cpupc,
    output logic [63:0] dnpc,
    output logic        not_jump,
    input  logic        out_accept
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      resp_pc_q, resp_pc_d;
    logic [3:0]       out_q, out_d;
    logic [3:0]       drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [63:0] pc_mem   [FIFO_DEPTH];

    logic       req_fire;
    logic       resp_fire;
    logic       resp_drop;
    logic       resp_keep;
    logic       push;
    logic       pop;
    logic [7:0] credit_used;

    // Slots already promised: kept responses still in flight plus buffered entries.
    assign credit_used = 8'(out_q) - 8'(drop_q) + 8'(cnt_q);

    assign imem_req_valid = !rst && !redirect_valid && (out_q < MAX_O)
                            && (credit_used < 8'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid;
    assign resp_drop = resp_fire && (drop_q != 4'd0);
    assign resp_keep = resp_fire && (drop_q == 4'd0);
    assign push      = resp_keep && !redirect_valid;
    assign pop       = validout && out_accept && !redirect_valid;

    assign validout = (cnt_q != '0);
    assign inst     = data_mem[rd_ptr_q];
    assign cpupc    = pc_mem[rd_ptr_q];
    assign dnpc     = cpupc + 64'd4;
    assign not_jump = validout;

    always_comb begin
        // NOTE: every next-state value gets its default first so no latch can be inferred.
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            out_d      = out_q - 4'(resp_fire);
            drop_d     = out_q - 4'(resp_fire);
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 64'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (resp_drop) begin
                drop_d = drop_q - 4'd1;
            end
            out_d = out_q + 4'(req_fire) - 4'(resp_fire);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: buffer storage is not reset; entry validity is tracked solely by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_drop_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (resp_fire && !push) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
            if (!imem_req_valid && !redirect_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed bench for ifu_fetch_stage: in-order memory responder with configurable
// latency, per-scenario tasks with inline comparisons against hand-derived values.
module tb_ifu_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUTSTANDING = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        validout;
    logic [31:0] inst;
    logic [63:0] cpupc;
    logic [63:0] dnpc;
    logic        not_jump;
    logic        out_accept;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    logic [63:0] pend_addr[$];
    int          pend_due[$];

    ifu_fetch_stage #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .validout(validout),
        .inst(inst),
        .cpupc(cpupc),
        .dnpc(dnpc),
        .not_jump(not_jump),
        .out_accept(out_accept)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ a[63:32];
    endfunction

    // In-order memory: records fires seen mid-cycle, answers after the chosen latency.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                end
                if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = '0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic restart(input logic rdy, input logic acc, input int lmin, input int lmax);
        next_cycle();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = rdy;
        out_accept = acc;
        lat_min = lmin;
        lat_max = lmax;
        next_cycle();
        rst = 1'b0;
    endtask

    // Waits (bounded) for validout; returns with the cycle sampled.
    task automatic wait_valid(input string name, output logic found);
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) begin
                next_cycle();
            end
            sample();
            if (validout) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        out_accept = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) next_cycle();
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b0 || validout !== 1'b0 || not_jump !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: req_valid=%b validout=%b not_jump=%b, want 0 0 0",
                     imem_req_valid, validout, not_jump);
        end
        next_cycle();
        rst = 1'b0;
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL first_req: valid=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        next_cycle();
        sample();
        n_checks++;
        if (imem_req_addr !== RESET_PC || validout !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_no_ready: addr=%h validout=%b, want %h 0", imem_req_addr, validout, RESET_PC);
        end
    endtask

    task automatic test_stream();
        restart(1'b1, 1'b1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            sample();
            n_checks++;
            if (imem_req_addr !== RESET_PC + 64'(4 * c) || imem_req_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_req%0d: valid=%b addr=%h, want 1 %h", c, imem_req_valid,
                         imem_req_addr, RESET_PC + 64'(4 * c));
            end
            if (c < 2) begin
                n_checks++;
                if (validout !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stream_early_valid%0d: validout=%b, want 0", c, validout);
                end
            end
        end
        n_checks++;
        if (validout !== 1'b1 || cpupc !== RESET_PC || dnpc !== RESET_PC + 64'd4
            || inst !== mem_word(RESET_PC) || not_jump !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_first_out: v=%b pc=%h dnpc=%h inst=%h nj=%b, want 1 %h %h %h 1",
                     validout, cpupc, dnpc, inst, not_jump, RESET_PC, RESET_PC + 64'd4, mem_word(RESET_PC));
        end
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            sample();
            n_checks++;
            if (validout !== 1'b1 || cpupc !== RESET_PC + 64'(4 * (k + 1))) begin
                n_errors++;
                $display("FAIL stream_seq%0d: v=%b pc=%h, want 1 %h", k, validout, cpupc,
                         RESET_PC + 64'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_backpressure();
        int fires;
        restart(1'b1, 1'b0, 1, 1);
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (imem_req_valid && imem_req_ready) fires++;
            next_cycle();
        end
        n_checks++;
        if (fires !== 4) begin
            n_errors++;
            $display("FAIL bp_fill_fires: got %0d, want 4", fires);
        end
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b0 || validout !== 1'b1 || cpupc !== RESET_PC
            || imem_req_addr !== RESET_PC + 64'd16) begin
            n_errors++;
            $display("FAIL bp_full_state: req_valid=%b v=%b pc=%h addr=%h, want 0 1 %h %h",
                     imem_req_valid, validout, cpupc, imem_req_addr, RESET_PC, RESET_PC + 64'd16);
        end
        next_cycle();
        out_accept = 1'b1;
        next_cycle();
        out_accept = 1'b0;
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (imem_req_valid && imem_req_ready) fires++;
            next_cycle();
        end
        n_checks++;
        if (fires !== 1) begin
            n_errors++;
            $display("FAIL bp_refill_fires: got %0d, want 1", fires);
        end
        imem_req_ready = 1'b0;
        out_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            n_checks++;
            if (validout !== 1'b1 || cpupc !== RESET_PC + 64'(4 * (k + 1))
                || inst !== mem_word(RESET_PC + 64'(4 * (k + 1)))) begin
                n_errors++;
                $display("FAIL bp_drain%0d: v=%b pc=%h inst=%h, want 1 %h %h", k, validout, cpupc, inst,
                         RESET_PC + 64'(4 * (k + 1)), mem_word(RESET_PC + 64'(4 * (k + 1))));
            end
            next_cycle();
        end
        sample();
        n_checks++;
        if (validout !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_empty: validout=%b, want 0", validout);
        end
    endtask

    task automatic test_redirect();
        logic found;
        restart(1'b1, 1'b1, 4, 4);
        sample();
        next_cycle();
        sample();
        next_cycle();
        sample();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_no_req: req_valid=%b, want 0", imem_req_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            n_errors++;
            $display("FAIL redir_new_req: valid=%b addr=%h, want 1 80001000", imem_req_valid, imem_req_addr);
        end
        wait_valid("redir", found);
        n_checks++;
        if (!found || cpupc !== 64'h8000_1000 || inst !== mem_word(64'h8000_1000)) begin
            n_errors++;
            $display("FAIL redir_first_out: found=%b pc=%h inst=%h, want 1 80001000 %h",
                     found, cpupc, inst, mem_word(64'h8000_1000));
        end
    endtask

    task automatic test_redirect_collision();
        logic found;
        restart(1'b1, 1'b1, 2, 2);
        sample();
        next_cycle();
        sample();
        next_cycle();
        sample();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        sample();
        n_checks++;
        if (validout !== 1'b1 || imem_resp_valid !== 1'b1 || cpupc !== RESET_PC) begin
            n_errors++;
            $display("FAIL coll_setup: v=%b resp=%b pc=%h, want 1 1 %h", validout, imem_resp_valid, cpupc, RESET_PC);
        end
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        n_checks++;
        if (validout !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
            n_errors++;
            $display("FAIL coll_after: v=%b req=%b addr=%h, want 0 1 80002000", validout, imem_req_valid, imem_req_addr);
        end
        wait_valid("coll", found);
        n_checks++;
        if (!found || cpupc !== 64'h8000_2000 || inst !== mem_word(64'h8000_2000)) begin
            n_errors++;
            $display("FAIL coll_first_out: found=%b pc=%h inst=%h, want 1 80002000 %h",
                     found, cpupc, inst, mem_word(64'h8000_2000));
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        restart(1'b1, 1'b1, 3, 3);
        sample();
        next_cycle();
        sample();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        sample();
        next_cycle();
        redirect_pc = 64'h8000_4000;
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_resp_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second: req=%b resp=%b, want 0 1", imem_req_valid, imem_resp_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        n_checks++;
        if (imem_req_addr !== 64'h8000_4000 || imem_req_valid !== 1'b1 || validout !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_req: addr=%h req=%b v=%b, want 80004000 1 0", imem_req_addr, imem_req_valid, validout);
        end
        wait_valid("b2b", found);
        n_checks++;
        if (!found || cpupc !== 64'h8000_4000) begin
            n_errors++;
            $display("FAIL b2b_first_out: found=%b pc=%h, want 1 80004000", found, cpupc);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        int consumed;
        int fires;
        restart(1'b1, 1'b0, 1, 5);
        exp_pc = RESET_PC;
        consumed = 0;
        fires = 0;
        for (int c = 0; c < 660; c++) begin
            if (c < 600) begin
                imem_req_ready = ($urandom_range(3, 0) != 0);
                out_accept = $urandom_range(1, 0) == 1;
            end else begin
                imem_req_ready = 1'b0;
                out_accept = 1'b1;
            end
            sample();
            if (imem_req_valid && imem_req_ready) fires++;
            n_checks++;
            if (pend_addr.size() > MAX_OUTSTANDING) begin
                n_errors++;
                $display("FAIL rand_outstanding: %0d in flight, limit %0d", pend_addr.size(), MAX_OUTSTANDING);
            end
            if (validout && out_accept) begin
                n_checks++;
                if (cpupc !== exp_pc || inst !== mem_word(exp_pc) || dnpc !== exp_pc + 64'd4 || not_jump !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_consume: pc=%h inst=%h dnpc=%h nj=%b, want %h %h %h 1",
                             cpupc, inst, dnpc, not_jump, exp_pc, mem_word(exp_pc), exp_pc + 64'd4);
                end
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            next_cycle();
        end
        n_checks++;
        if (consumed != fires || consumed < 50 || validout !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_totals: consumed=%0d fires=%0d v=%b, want equal (>=50) and 0",
                     consumed, fires, validout);
        end
    endtask

    task automatic test_reset_midstream();
        logic found;
        restart(1'b1, 1'b0, 1, 1);
        repeat (10) next_cycle();
        sample();
        n_checks++;
        if (validout !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_full: v=%b req=%b, want 1 0", validout, imem_req_valid);
        end
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        sample();
        n_checks++;
        if (validout !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: v=%b req=%b, want 0 0", validout, imem_req_valid);
        end
        next_cycle();
        rst = 1'b0;
        out_accept = 1'b1;
        sample();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || validout !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_restart: req=%b addr=%h v=%b, want 1 %h 0", imem_req_valid, imem_req_addr, validout, RESET_PC);
        end
        wait_valid("mid", found);
        n_checks++;
        if (!found || cpupc !== RESET_PC || inst !== mem_word(RESET_PC)) begin
            n_errors++;
            $display("FAIL mid_first_out: found=%b pc=%h inst=%h, want 1 %h %h", found, cpupc, inst,
                     RESET_PC, mem_word(RESET_PC));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collision();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
